// File: rtl/mealy_seq_ctrl.sv
// mealy_seq_ctrl
//   Serializes one WIDTH-bit frame into an external Mealy sequence detector
//   and counts how many cycles the detector flags a match while the frame
//   is being shifted out.
//
//   Handshake: a frame is accepted on a rising edge where start=1 and
//   ready=1. ready is high only in IDLE. Any start seen while busy is
//   dropped (no queuing). done is a one-cycle pulse in REPORT; match_cnt
//   is valid from that cycle and holds until the next accepted frame.
//
//   Ports
//     clk        : rising-edge clock
//     reset      : synchronous active-high reset
//     start      : frame request
//     data_in    : frame to serialize, captured on acceptance
//     det_z      : detector output, sampled on every SHIFT edge
//     ready      : controller idle, can accept a frame
//     busy       : controller in CLR / SHIFT / REPORT
//     det_reset  : reset pulse to the detector (reset OR CLR)
//     ser_out    : serial bit to the detector, 0 outside SHIFT
//     match_cnt  : saturating count of det_z=1 cycles in the last frame
//     done       : one-cycle pulse when match_cnt becomes valid
//     dbg_state  : current FSM state (0 IDLE, 1 CLR, 2 SHIFT, 3 REPORT)
module mealy_seq_ctrl #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic             det_z,
    output logic             ready,
    output logic             busy,
    output logic             det_reset,
    output logic             ser_out,
    output logic [3:0]       match_cnt,
    output logic             done,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CLR    = 2'd1,
        S_SHIFT  = 2'd2,
        S_REPORT = 2'd3
    } state_t;

    localparam int CW = $clog2(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_q;
    logic [CW-1:0]    cnt_q;
    logic [3:0]       mc_q;
    logic             last_bit;
    logic             head_bit;

    assign last_bit = (cnt_q == CW'(WIDTH - 1));
    assign head_bit = MSB_FIRST ? sh_q[WIDTH-1] : sh_q[0];

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_CLR;
            S_CLR:    state_d = S_SHIFT;
            S_SHIFT:  if (last_bit) state_d = S_REPORT;
            S_REPORT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Datapath: shift register, bit counter, match counter.
    // det_z is only looked at on SHIFT edges, i.e. the edge that retires
    // the bit currently on ser_out, which captures the detector's
    // same-cycle Mealy response to that bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            sh_q  <= '0;
            cnt_q <= '0;
            mc_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        sh_q  <= data_in;
                        cnt_q <= '0;
                        mc_q  <= '0;
                    end
                end
                S_SHIFT: begin
                    if (MSB_FIRST) begin
                        sh_q <= {sh_q[WIDTH-2:0], 1'b0};
                    end else begin
                        sh_q <= {1'b0, sh_q[WIDTH-1:1]};
                    end
                    cnt_q <= last_bit ? '0 : cnt_q + 1'b1;
                    // Saturate rather than wrap so a long frame with many
                    // matches still reads as "at least 15".
                    if (det_z && (mc_q != 4'hF)) begin
                        mc_q <= mc_q + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs, decoded from state/registers only. The reset term on
    // det_reset lets the detector be reset together with the controller.
    always_comb begin
        ready     = (state_q == S_IDLE);
        busy      = (state_q != S_IDLE);
        det_reset = reset | (state_q == S_CLR);
        ser_out   = (state_q == S_SHIFT) & head_bit;
        done      = (state_q == S_REPORT);
        match_cnt = mc_q;
        dbg_state = state_q;
    end

endmodule

// File: tb/tb_mealy_seq_ctrl.sv
// Bench for mealy_seq_ctrl. Three instances: 0 = WIDTH 8 MSB first,
// 1 = WIDTH 8 LSB first, 2 = WIDTH 16 MSB first.
// Expected entry layout: {tag[1:0], bits[15:0], cnt[3:0], lat[7:0]} where
// bits[i] is the i-th serialized bit and lat counts cycles from the
// acceptance edge to the cycle in which done is high.
module tb_mealy_seq_ctrl;

    logic        clk;
    logic        reset;
    logic [2:0]  start_w;
    logic [2:0]  det_z_w;
    logic [15:0] data_w [3];
    logic [2:0]  ready_w, busy_w, det_reset_w, ser_w, done_w;
    logic [3:0]  mc_w [3];
    logic [1:0]  st_w [3];

    logic [29:0] exp_q[$];
    int          total;
    int          bad;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUTs + monitors ----------------
    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int W  = (g == 2) ? 16 : 8;
        localparam bit MF = (g == 1) ? 1'b0 : 1'b1;

        mealy_seq_ctrl #(.WIDTH(W), .MSB_FIRST(MF)) u_dut (
            .clk       (clk),
            .reset     (reset),
            .start     (start_w[g]),
            .data_in   (data_w[g][W-1:0]),
            .det_z     (det_z_w[g]),
            .ready     (ready_w[g]),
            .busy      (busy_w[g]),
            .det_reset (det_reset_w[g]),
            .ser_out   (ser_w[g]),
            .match_cnt (mc_w[g]),
            .done      (done_w[g]),
            .dbg_state (st_w[g])
        );

        logic [15:0] bits;
        int          nb;
        int          lat;
        bit          active;

        always @(negedge clk) begin
            logic [29:0] e;
            bit          shift_now;
            if (reset) begin
                active = 1'b0;
                nb     = 0;
                lat    = 0;
                bits   = '0;
            end else begin
                shift_now = busy_w[g] && !det_reset_w[g] && !done_w[g];
                if (active) lat++;
                if (shift_now) begin
                    if (nb < 16) bits[nb] = ser_w[g];
                    nb++;
                end else begin
                    chk("ser_out_idle", g, 32'(ser_w[g]), 32'd0);
                end
                if (done_w[g]) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_done dut=%0d got done=1 required no pulse", g);
                    end else begin
                        e = exp_q.pop_front();
                        chk("tag",       g, 32'(g),       32'(e[29:28]));
                        chk("ser_bits",  g, 32'(bits),    32'(e[27:12]));
                        chk("nbits",     g, 32'(nb),      32'(W));
                        chk("match_cnt", g, 32'(mc_w[g]), 32'(e[11:8]));
                        chk("latency",   g, 32'(lat),     32'(e[7:0]));
                    end
                    active = 1'b0;
                end
                if (start_w[g] && ready_w[g]) begin
                    active = 1'b1;
                    lat    = 0;
                    nb     = 0;
                    bits   = '0;
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input int g, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut=%0d got=0x%0h required=0x%0h", name, g, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int wof(input int g);
        return (g == 2) ? 16 : 8;
    endfunction

    // ---------------- driver ----------------
    // zside is det_z during CLR and REPORT (must be ignored).
    task automatic run_frame(input int g, input logic [15:0] data,
                             input logic [15:0] zmask, input logic zside,
                             input logic [15:0] exp_bits, input logic [3:0] exp_cnt);
        int w;
        w = wof(g);
        exp_q.push_back({2'(g), exp_bits, exp_cnt, 8'(w + 2)});
        start_w[g] = 1'b1;
        data_w[g]  = data;
        det_z_w[g] = zside;
        step();                         // acceptance edge -> CLR
        start_w[g] = 1'b0;
        det_z_w[g] = zside;
        step();                         // -> SHIFT cycle 1
        for (int i = 0; i < w; i++) begin
            det_z_w[g] = zmask[i];
            step();
        end
        det_z_w[g] = zside;             // REPORT
        step();
        det_z_w[g] = 1'b0;              // back in IDLE
        step();
        step();
        @(negedge clk);
        chk("match_cnt_hold", g, 32'(mc_w[g]), 32'(exp_cnt));
        step();
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) step();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        total   = 0;
        bad     = 0;
        reset   = 1'b1;
        start_w = '0;
        det_z_w = '0;
        for (int g = 0; g < 3; g++) data_w[g] = '0;

        // reset state
        step();
        step();
        @(negedge clk);
        chk("det_reset_in_reset", 0, 32'(det_reset_w), 32'h7);
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 0, 32'(ready_w), 32'h7);
        chk("busy_after_reset",  0, 32'(busy_w),  32'h0);
        chk("done_after_reset",  0, 32'(done_w),  32'h0);
        chk("ser_after_reset",   0, 32'(ser_w),   32'h0);
        chk("det_reset_release", 0, 32'(det_reset_w), 32'h0);
        for (int g = 0; g < 3; g++) begin
            chk("mc_after_reset", g, 32'(mc_w[g]), 32'h0);
            chk("state_after_reset", g, 32'(st_w[g]), 32'h0);
        end
        step();

        // MSB first, WIDTH 8
        run_frame(0, 16'h00A5, 16'h0000, 1'b0, 16'h00A5, 4'd0);
        run_frame(0, 16'h00A5, 16'h0012, 1'b1, 16'h00A5, 4'd2);
        run_frame(0, 16'h0001, 16'h0000, 1'b0, 16'h0080, 4'd0);
        // LSB first, WIDTH 8
        run_frame(1, 16'h00A5, 16'h0000, 1'b0, 16'h00A5, 4'd0);
        run_frame(1, 16'h0001, 16'h0000, 1'b0, 16'h0001, 4'd0);
        run_frame(1, 16'h00FF, 16'h00FF, 1'b1, 16'h00FF, 4'd8);
        // WIDTH 16, every SHIFT cycle a match -> saturates at 15
        run_frame(2, 16'h1234, 16'hFFFF, 1'b1, 16'h2C48, 4'hF);
        drain();

        // reset in SHIFT cycle 4 aborts the frame
        start_w[0] = 1'b1;
        data_w[0]  = 16'h00C3;
        step();
        start_w[0] = 1'b0;
        det_z_w[0] = 1'b1;
        step();
        step();
        step();
        step();                         // now in SHIFT cycle 4
        reset = 1'b1;
        @(negedge clk);
        chk("mc_before_abort", 0, 32'(mc_w[0]), 32'd3);
        chk("det_reset_abort", 0, 32'(det_reset_w), 32'h7);
        step();
        reset      = 1'b0;
        det_z_w[0] = 1'b0;
        @(negedge clk);
        chk("ready_after_abort", 0, 32'(ready_w[0]), 32'd1);
        chk("busy_after_abort",  0, 32'(busy_w[0]),  32'd0);
        chk("mc_after_abort",    0, 32'(mc_w[0]),    32'd0);
        step();
        step();
        run_frame(0, 16'h00A5, 16'h0012, 1'b1, 16'h00A5, 4'd2);
        drain();

        // reset wins over start in the same cycle
        reset      = 1'b1;
        start_w[1] = 1'b1;
        data_w[1]  = 16'h0055;
        step();
        reset      = 1'b0;
        start_w[1] = 1'b0;
        @(negedge clk);
        chk("ready_reset_prio", 1, 32'(ready_w[1]), 32'd1);
        chk("busy_reset_prio",  1, 32'(busy_w[1]),  32'd0);
        step();

        // start held high: acceptances at edges 0, 11, 22
        for (int k = 0; k < 3; k++) exp_q.push_back({2'd0, 16'h003C, 4'd0, 8'd10});
        data_w[0]  = 16'h003C;
        det_z_w[0] = 1'b0;
        start_w[0] = 1'b1;
        for (int k = 0; k < 23; k++) step();
        start_w[0] = 1'b0;
        drain();
        for (int k = 0; k < 15; k++) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
